// File: rtl/vga_draw_arbiter.sv
// Fixed-priority arbiter that rasterises one latched rectangle at a time into
// a single-pixel-per-cycle plot port, clipping against the visible screen.
module vga_draw_arbiter #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic        Clock,
    input  logic        reset,
    input  logic [2:0]  req,
    input  logic [23:0] rx,
    input  logic [20:0] ry,
    input  logic [23:0] rw,
    input  logic [20:0] rh,
    input  logic [8:0]  rcol,
    input  logic        abort,
    output logic [2:0]  grant,
    output logic [2:0]  done,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic [2:0]  colour,
    output logic        writeEn,
    output logic        busy
);

    // Handshake: a requester holds req[i] until it sees grant[i] (a one-cycle
    // pulse in the first DRAW cycle); done[i] pulses once in the DONE cycle and
    // busy spans grant through done inclusive. Nothing is queued while busy.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [8:0] SCR_W = 9'(SCREEN_W);
    localparam logic [7:0] SCR_H = 8'(SCREEN_H);

    state_t      state_q, state_d;
    logic [1:0]  win_q, win_d;
    logic [7:0]  x0_q, x0_d;
    logic [6:0]  y0_q, y0_d;
    logic [7:0]  w_q, w_d;
    logic [6:0]  h_q, h_d;
    logic [2:0]  col_q, col_d;
    logic [7:0]  cx_q, cx_d;
    logic [6:0]  cy_q, cy_d;
    logic        first_q, first_d;

    logic [1:0]  win_sel;
    logic [7:0]  sel_x, sel_w;
    logic [6:0]  sel_y, sel_h;
    logic [2:0]  sel_col;
    logic        empty_rect;
    logic        last_pixel;
    logic [8:0]  sum_x;
    logic [7:0]  sum_y;
    logic        on_screen;

    always_comb begin
        win_sel = 2'd2;
        if (req[0]) begin
            win_sel = 2'd0;
        end else if (req[1]) begin
            win_sel = 2'd1;
        end
    end

    always_comb begin
        sel_x   = rx[23:16];
        sel_y   = ry[20:14];
        sel_w   = rw[23:16];
        sel_h   = rh[20:14];
        sel_col = rcol[8:6];
        case (win_sel)
            2'd0: begin
                sel_x   = rx[7:0];
                sel_y   = ry[6:0];
                sel_w   = rw[7:0];
                sel_h   = rh[6:0];
                sel_col = rcol[2:0];
            end
            2'd1: begin
                sel_x   = rx[15:8];
                sel_y   = ry[13:7];
                sel_w   = rw[15:8];
                sel_h   = rh[13:7];
                sel_col = rcol[5:3];
            end
            default: ;
        endcase
    end

    assign empty_rect = (w_q == 8'd0) || (h_q == 7'd0);
    assign last_pixel = (cx_q == w_q - 8'd1) && (cy_q == h_q - 7'd1);

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        x0_d    = x0_q;
        y0_d    = y0_q;
        w_d     = w_q;
        h_d     = h_q;
        col_d   = col_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        first_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (req != 3'b000) begin
                    state_d = DRAW;
                    win_d   = win_sel;
                    x0_d    = sel_x;
                    y0_d    = sel_y;
                    w_d     = sel_w;
                    h_d     = sel_h;
                    col_d   = sel_col;
                    cx_d    = 8'd0;
                    cy_d    = 7'd0;
                    first_d = 1'b1;
                end
            end
            DRAW: begin
                // A degenerate rectangle still spends its one grant cycle here.
                if (abort || empty_rect || last_pixel) begin
                    state_d = DONE;
                end else if (cx_q == w_q - 8'd1) begin
                    cx_d = 8'd0;
                    cy_d = cy_q + 7'd1;
                end else begin
                    cx_d = cx_q + 8'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            win_q   <= 2'd0;
            x0_q    <= 8'd0;
            y0_q    <= 7'd0;
            w_q     <= 8'd0;
            h_q     <= 7'd0;
            col_q   <= 3'd0;
            cx_q    <= 8'd0;
            cy_q    <= 7'd0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            x0_q    <= x0_d;
            y0_q    <= y0_d;
            w_q     <= w_d;
            h_q     <= h_d;
            col_q   <= col_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            first_q <= first_d;
        end
    end

    // Sums are one bit wider so coordinates that wrap are still clipped.
    assign sum_x     = {1'b0, x0_q} + {1'b0, cx_q};
    assign sum_y     = {1'b0, y0_q} + {1'b0, cy_q};
    assign on_screen = (sum_x < SCR_W) && (sum_y < SCR_H);

    assign x       = sum_x[7:0];
    assign y       = sum_y[6:0];
    assign colour  = col_q;
    assign writeEn = (state_q == DRAW) && !empty_rect && on_screen && !abort;
    assign grant   = first_q ? (3'b001 << win_q) : 3'b000;
    assign done    = (state_q == DONE) ? (3'b001 << win_q) : 3'b000;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// Directed bench for vga_draw_arbiter: a pixel-list model predicts every cycle,
// and literal expectations pin the scenarios from the requirements.
module tb_vga_draw_arbiter;

    logic        Clock;
    logic        reset;
    logic [2:0]  req;
    logic [23:0] rx;
    logic [20:0] ry;
    logic [23:0] rw;
    logic [20:0] rh;
    logic [8:0]  rcol;
    logic        abort;
    logic [2:0]  grant;
    logic [2:0]  done;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        writeEn;
    logic        busy;

    vga_draw_arbiter #(.SCREEN_W(160), .SCREEN_H(120)) dut (
        .Clock(Clock), .reset(reset), .req(req), .rx(rx), .ry(ry), .rw(rw),
        .rh(rh), .rcol(rcol), .abort(abort), .grant(grant), .done(done),
        .x(x), .y(y), .colour(colour), .writeEn(writeEn), .busy(busy)
    );

    // ---------------- clock ----------------
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- model: queue of pixels still owed ----------------
    // Each entry is {on_screen, y, x} for one DRAW cycle of the current grant.
    logic [15:0] exp_q[$];
    logic        m_active = 1'b0;
    logic        m_first = 1'b0;
    logic        m_done = 1'b0;
    int          m_win = 0;
    logic [2:0]  m_col = 3'd0;
    int          b_x0, b_y0, b_w, b_h, b_xs, b_ys;

    always @(posedge Clock or negedge reset) begin
        if (!reset) begin
            m_active = 1'b0;
            m_first  = 1'b0;
            m_done   = 1'b0;
            exp_q.delete();
        end else begin
            cyc++;
            if (m_done) begin
                m_done = 1'b0;
            end else if (m_active) begin
                void'(exp_q.pop_front());
                m_first = 1'b0;
                if (abort || exp_q.size() == 0) begin
                    exp_q.delete();
                    m_active = 1'b0;
                    m_done   = 1'b1;
                end
            end else if (req != 3'b000) begin
                m_win = req[0] ? 0 : (req[1] ? 1 : 2);
                b_x0  = int'(rx[8*m_win +: 8]);
                b_y0  = int'(ry[7*m_win +: 7]);
                b_w   = int'(rw[8*m_win +: 8]);
                b_h   = int'(rh[7*m_win +: 7]);
                m_col = rcol[3*m_win +: 3];
                if (b_w == 0 || b_h == 0) begin
                    exp_q.push_back({1'b0, 7'(b_y0), 8'(b_x0)});
                end else begin
                    for (int cy = 0; cy < b_h; cy++) begin
                        for (int cx = 0; cx < b_w; cx++) begin
                            b_xs = b_x0 + cx;
                            b_ys = b_y0 + cy;
                            exp_q.push_back({(b_xs < 160 && b_ys < 120), 7'(b_ys), 8'(b_xs)});
                        end
                    end
                end
                m_active = 1'b1;
                m_first  = 1'b1;
            end
        end
    end

    // ---------------- scoreboard / monitor ----------------
    logic [14:0] wr_log[$];
    logic [2:0]  g_log[$];
    int          g_cyc[$];
    logic [2:0]  d_log[$];
    int          d_cyc[$];
    int          busy_cnt = 0;

    always @(negedge Clock) begin
        if (reset === 1'b1) begin
            if (m_active) begin
                chk("grant", 32'(grant), m_first ? 32'(3'b001 << m_win) : 32'd0);
                chk("done", 32'(done), 32'd0);
                chk("busy", 32'(busy), 32'd1);
                chk("writeEn", 32'(writeEn), 32'(exp_q[0][15] && !abort));
                chk("x", 32'(x), 32'(exp_q[0][7:0]));
                chk("y", 32'(y), 32'(exp_q[0][14:8]));
                chk("colour", 32'(colour), 32'(m_col));
            end else if (m_done) begin
                chk("grant", 32'(grant), 32'd0);
                chk("done", 32'(done), 32'(3'b001 << m_win));
                chk("busy", 32'(busy), 32'd1);
                chk("writeEn", 32'(writeEn), 32'd0);
            end else begin
                chk("grant", 32'(grant), 32'd0);
                chk("done", 32'(done), 32'd0);
                chk("busy", 32'(busy), 32'd0);
                chk("writeEn", 32'(writeEn), 32'd0);
            end
            if (writeEn) wr_log.push_back({y, x});
            if (grant != 3'b000) begin
                g_log.push_back(grant);
                g_cyc.push_back(cyc);
            end
            if (done != 3'b000) begin
                d_log.push_back(done);
                d_cyc.push_back(cyc);
            end
            if (busy) busy_cnt++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_rect(input int i, input int x0, input int y0, input int w, input int h, input int col);
        rx[8*i +: 8]   = 8'(x0);
        ry[7*i +: 7]   = 7'(y0);
        rw[8*i +: 8]   = 8'(w);
        rh[7*i +: 7]   = 7'(h);
        rcol[3*i +: 3] = 3'(col);
    endtask

    task automatic clear_logs();
        wr_log.delete();
        g_log.delete();
        g_cyc.delete();
        d_log.delete();
        d_cyc.delete();
        busy_cnt = 0;
    endtask

    // Hold the given requests, drop each bit once granted, return when idle.
    task automatic run_req(input logic [2:0] r, input string name);
        bit finished = 1'b0;
        req = r;
        for (int n = 0; n < 30000 && !finished; n++) begin
            @(posedge Clock);
            #1;
            req = req & ~grant;
            if (req == 3'b000 && !busy) finished = 1'b1;
        end
        if (!finished) chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_grant(input string name);
        bit seen = 1'b0;
        for (int n = 0; n < 100 && !seen; n++) begin
            @(posedge Clock);
            #1;
            if (grant != 3'b000) seen = 1'b1;
        end
        if (!seen) chk({name, "_grant_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic chk_zero_outputs(input string name);
        chk({name, "_grant"}, 32'(grant), 32'd0);
        chk({name, "_done"}, 32'(done), 32'd0);
        chk({name, "_writeEn"}, 32'(writeEn), 32'd0);
        chk({name, "_busy"}, 32'(busy), 32'd0);
        chk({name, "_x"}, 32'(x), 32'd0);
        chk({name, "_y"}, 32'(y), 32'd0);
        chk({name, "_colour"}, 32'(colour), 32'd0);
    endtask

    // ---------------- directed scenarios ----------------
    logic [14:0] pix41 [6];
    logic [14:0] pix43 [4];
    int abort_cyc;

    initial begin
        reset = 1'b0;
        req   = 3'b000;
        abort = 1'b0;
        rx = '0; ry = '0; rw = '0; rh = '0; rcol = '0;
        repeat (3) @(posedge Clock);
        #1;
        chk_zero_outputs("reset");
        reset = 1'b1;
        @(posedge Clock);
        #1;

        // Dino 3x2 at (10,90)
        pix41[0] = {7'd90, 8'd10}; pix41[1] = {7'd90, 8'd11}; pix41[2] = {7'd90, 8'd12};
        pix41[3] = {7'd91, 8'd10}; pix41[4] = {7'd91, 8'd11}; pix41[5] = {7'd91, 8'd12};
        clear_logs();
        set_rect(1, 10, 90, 3, 2, 3'b110);
        run_req(3'b010, "dino");
        chk("dino_grants", 32'(g_log.size()), 32'd1);
        chk("dino_writes", 32'(wr_log.size()), 32'd6);
        if (wr_log.size() == 6) begin
            for (int i = 0; i < 6; i++) chk("dino_pixel", 32'(wr_log[i]), 32'(pix41[i]));
        end
        if (g_log.size() == 1 && d_log.size() == 1) begin
            chk("dino_grant_val", 32'(g_log[0]), 32'(3'b010));
            chk("dino_done_val", 32'(d_log[0]), 32'(3'b010));
            chk("dino_done_cycle", 32'(d_cyc[0]), 32'(g_cyc[0] + 6));
        end

        // Simultaneous requests from all three
        clear_logs();
        set_rect(0, 0, 0, 2, 1, 3'b001);
        set_rect(1, 5, 5, 1, 2, 3'b010);
        set_rect(2, 7, 7, 2, 2, 3'b100);
        run_req(3'b111, "prio");
        chk("prio_grants", 32'(g_log.size()), 32'd3);
        if (g_log.size() == 3 && d_log.size() == 3) begin
            chk("prio_g0", 32'(g_log[0]), 32'(3'b001));
            chk("prio_g1", 32'(g_log[1]), 32'(3'b010));
            chk("prio_g2", 32'(g_log[2]), 32'(3'b100));
            chk("prio_gap1", 32'(g_cyc[1]), 32'(d_cyc[0] + 2));
            chk("prio_gap2", 32'(g_cyc[2]), 32'(d_cyc[1] + 2));
        end

        // Obstacle straddling the bottom-right corner
        pix43[0] = {7'd118, 8'd158}; pix43[1] = {7'd118, 8'd159};
        pix43[2] = {7'd119, 8'd158}; pix43[3] = {7'd119, 8'd159};
        clear_logs();
        set_rect(2, 158, 118, 4, 3, 3'b011);
        run_req(3'b100, "clip");
        chk("clip_writes", 32'(wr_log.size()), 32'd4);
        if (wr_log.size() == 4) begin
            for (int i = 0; i < 4; i++) chk("clip_pixel", 32'(wr_log[i]), 32'(pix43[i]));
        end
        chk("clip_busy", 32'(busy_cnt), 32'd13);

        // Zero-width clear, with abort raised during DONE (must be ignored)
        clear_logs();
        set_rect(0, 3, 3, 0, 5, 3'b111);
        req = 3'b001;
        wait_grant("empty");
        req = 3'b000;
        @(posedge Clock);
        #1;
        abort = 1'b1;
        @(posedge Clock);
        #1;
        abort = 1'b0;
        run_req(3'b000, "empty");
        chk("empty_writes", 32'(wr_log.size()), 32'd0);
        chk("empty_busy", 32'(busy_cnt), 32'd2);
        if (g_cyc.size() == 1 && d_cyc.size() == 1)
            chk("empty_done_cycle", 32'(d_cyc[0]), 32'(g_cyc[0] + 1));

        // Full-screen clear aborted on DRAW cycle 100
        clear_logs();
        set_rect(0, 0, 0, 160, 120, 3'b000);
        req = 3'b001;
        wait_grant("abort");
        req = 3'b000;
        repeat (99) begin
            @(posedge Clock);
            #1;
        end
        abort = 1'b1;
        abort_cyc = cyc;
        @(posedge Clock);
        #1;
        abort = 1'b0;
        run_req(3'b000, "abort");
        chk("abort_writes", 32'(wr_log.size()), 32'd99);
        if (wr_log.size() == 99) chk("abort_last_pixel", 32'(wr_log[98]), 32'({7'd0, 8'd98}));
        chk("abort_dones", 32'(d_log.size()), 32'd1);
        if (d_log.size() == 1) begin
            chk("abort_done_val", 32'(d_log[0]), 32'(3'b001));
            chk("abort_done_cycle", 32'(d_cyc[0]), 32'(abort_cyc + 1));
        end

        // Reset asserted on DRAW cycle 3 of a 4x4 rect, request held through
        clear_logs();
        set_rect(1, 20, 30, 4, 4, 3'b101);
        req = 3'b010;
        wait_grant("rst");
        @(posedge Clock);
        #1;
        @(posedge Clock);
        #2;
        reset = 1'b0;
        #1;
        chk_zero_outputs("rst_mid");
        chk("rst_no_done", 32'(d_log.size()), 32'd0);
        @(posedge Clock);
        #1;
        @(posedge Clock);
        #1;
        clear_logs();
        reset = 1'b1;
        run_req(3'b010, "rst");
        chk("rst_grants", 32'(g_log.size()), 32'd1);
        if (g_log.size() == 1) chk("rst_grant_val", 32'(g_log[0]), 32'(3'b010));
        chk("rst_writes", 32'(wr_log.size()), 32'd16);
        if (wr_log.size() == 16) chk("rst_first_pixel", 32'(wr_log[0]), 32'({7'd30, 8'd20}));
        chk("rst_busy", 32'(busy_cnt), 32'd17);

        repeat (3) @(posedge Clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
